// File: rtl/fp_accumulator.sv
// Streaming accumulator front end for a combinational floating point adder.
// Sums a valid/ready operand stream and presents the final sum with sticky flags.
module fp_accumulator #(
    parameter int BIT_SIZE = 32,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BIT_SIZE-1:0] in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BIT_SIZE-1:0] out_data,
    output logic [CNT_W-1:0]    out_count,
    output logic                out_overflow,
    output logic                out_NaN,
    output logic                out_precLost,
    output logic [BIT_SIZE-1:0] add_num0,
    output logic [BIT_SIZE-1:0] add_num1,
    input  logic [BIT_SIZE-1:0] add_res,
    input  logic                add_overflow,
    input  logic                add_NaN,
    input  logic                add_precLost
);

    localparam int EXP_W  = (BIT_SIZE == 64) ? 11 : 8;
    localparam int FRAC_W = BIT_SIZE - 1 - EXP_W;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [BIT_SIZE-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } stateT;

    stateT state;
    stateT stateNext;

    logic [BIT_SIZE-1:0] acc;
    logic [CNT_W-1:0]    count;
    logic                overflowSticky;
    logic                nanSticky;
    logic                precLostSticky;
    logic                accept;
    logic                inIsNaN;

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid & in_ready;

    assign inIsNaN = (&in_data[BIT_SIZE-2:FRAC_W])
                   & (|in_data[FRAC_W-1:0]);

    assign add_num0 = acc;
    assign add_num1 = in_data;

    assign out_data     = nanSticky ? QNAN : acc;
    assign out_count    = count;
    assign out_overflow = overflowSticky;
    assign out_NaN      = nanSticky;
    assign out_precLost = precLostSticky;

    // State register; reset returns to IDLE regardless of traffic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state: streams open on first accept, close on last beat, drain on out_ready.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    stateNext = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept && in_last) begin
                    stateNext = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Datapath: first beat loads directly, later beats take the adder result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc            <= '0;
            count          <= '0;
            overflowSticky <= 1'b0;
            nanSticky      <= 1'b0;
            precLostSticky <= 1'b0;
        end else if (accept && state == IDLE) begin
            acc            <= in_data;
            count          <= CNT_ONE;
            overflowSticky <= 1'b0;
            nanSticky      <= inIsNaN;
            precLostSticky <= 1'b0;
        end else if (accept && state == ACCUM) begin
            acc            <= add_res;
            count          <= (count == CNT_MAX) ? count : count + CNT_ONE;
            overflowSticky <= overflowSticky | add_overflow;
            nanSticky      <= nanSticky | add_NaN;
            precLostSticky <= precLostSticky | add_precLost;
        end
    end

endmodule

// File: tb/tb_fp_accumulator.sv
// Directed bench for fp_accumulator with a table-driven stand-in adder.
// Expected results are hand-computed binary32 sums.
module tb_fp_accumulator;

    localparam int BW = 32;
    localparam int CW = 3;

    logic          clk;
    logic          rst_n;
    logic          inValid;
    logic          inReady;
    logic [BW-1:0] inData;
    logic          inLast;
    logic          outValid;
    logic          outReady;
    logic [BW-1:0] outData;
    logic [CW-1:0] outCount;
    logic          outOverflow;
    logic          outNaN;
    logic          outPrecLost;
    logic [BW-1:0] addNum0;
    logic [BW-1:0] addNum1;
    logic [BW-1:0] addRes;
    logic          addOverflow;
    logic          addNaN;
    logic          addPrecLost;

    int checks;
    int failures;

    fp_accumulator #(.BIT_SIZE(BW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (inValid),
        .in_ready     (inReady),
        .in_data      (inData),
        .in_last      (inLast),
        .out_valid    (outValid),
        .out_ready    (outReady),
        .out_data     (outData),
        .out_count    (outCount),
        .out_overflow (outOverflow),
        .out_NaN      (outNaN),
        .out_precLost (outPrecLost),
        .add_num0     (addNum0),
        .add_num1     (addNum1),
        .add_res      (addRes),
        .add_overflow (addOverflow),
        .add_NaN      (addNaN),
        .add_precLost (addPrecLost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in adder: {res, overflow, NaN, precLost} for the pairs used here.
    function automatic logic [34:0] adderModel(input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] key;
        key = {a, b};
        case (key)
            64'h3F800000_40000000: return {32'h40400000, 3'b000};
            64'h40400000_40400000: return {32'h40C00000, 3'b000};
            64'h3F800000_7FC00000: return {32'h7FC00000, 3'b010};
            64'h7FC00000_3F800000: return {32'h7FC00000, 3'b010};
            64'h7F7FFFFF_7F7FFFFF: return {32'h7F800000, 3'b100};
            64'h4B800000_3F800000: return {32'h4B800000, 3'b001};
            64'h40000000_40000000: return {32'h40800000, 3'b000};
            64'h00000000_00000000: return {32'h00000000, 3'b000};
            default:               return {32'hDEADBEEF, 3'b111};
        endcase
    endfunction

    always_comb begin
        {addRes, addOverflow, addNaN, addPrecLost} = adderModel(addNum0, addNum1);
    end

    task automatic checkEq(input string tag,
                           input logic [63:0] got,
                           input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one beat; it is accepted on the next edge.
    task automatic sendBeat(input logic [31:0] d, input logic l);
        inValid = 1'b1;
        inData  = d;
        inLast  = l;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        inLast  = 1'b0;
    endtask

    task automatic checkResult(input string tag,
                               input logic [31:0] d,
                               input logic [CW-1:0] c,
                               input logic [2:0] f);
        checkEq({tag, "_valid"}, outValid, 1'b1);
        checkEq({tag, "_ready"}, inReady, 1'b0);
        checkEq({tag, "_data"}, outData, d);
        checkEq({tag, "_count"}, outCount, c);
        checkEq({tag, "_flags"}, {outOverflow, outNaN, outPrecLost}, f);
    endtask

    task automatic release_(input string tag);
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        checkEq({tag, "_idleValid"}, outValid, 1'b0);
        checkEq({tag, "_idleReady"}, inReady, 1'b1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        inLast   = 1'b0;
        outReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        checkEq("rst_valid", outValid, 1'b0);
        checkEq("rst_ready", inReady, 1'b1);
        checkEq("rst_data", outData, 32'h0);
        checkEq("rst_count", outCount, 3'd0);
        checkEq("rst_flags", {outOverflow, outNaN, outPrecLost}, 3'b000);

        // 1.0 + 2.0 + 3.0, with adder operand wiring checked mid-stream
        sendBeat(32'h3F800000, 1'b0);
        inData = 32'h40000000;
        #1;
        checkEq("t1_num0", addNum0, 32'h3F800000);
        checkEq("t1_num1", addNum1, 32'h40000000);
        sendBeat(32'h40000000, 1'b0);
        sendBeat(32'h40400000, 1'b1);
        checkResult("t1", 32'h40C00000, 3'd3, 3'b000);

        // Held result stays put and input is refused while out_ready is low
        inValid = 1'b1;
        inData  = 32'h40000000;
        inLast  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkResult("t3_hold", 32'h40C00000, 3'd3, 3'b000);
        end
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        inValid  = 1'b0;
        inLast   = 1'b0;
        checkEq("t3_idleValid", outValid, 1'b0);
        checkEq("t3_noBubbleAccept", outCount, 3'd3);
        checkEq("t3_keptData", outData, 32'h40C00000);

        // Single-beat stream
        sendBeat(32'hC0490FDB, 1'b1);
        checkResult("t2", 32'hC0490FDB, 3'd1, 3'b000);
        release_("t2");

        // NaN operand mid-stream
        sendBeat(32'h3F800000, 1'b0);
        sendBeat(32'h7FC00000, 1'b0);
        sendBeat(32'h3F800000, 1'b1);
        checkResult("t4", 32'h7FC00000, 3'd3, 3'b010);
        release_("t4");

        // Overflow to +inf, with idle gaps that must not count
        sendBeat(32'h7F7FFFFF, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkEq("t5_gapValid", outValid, 1'b0);
        sendBeat(32'h7F7FFFFF, 1'b1);
        checkResult("t5", 32'h7F800000, 3'd2, 3'b100);
        release_("t5");

        // Precision loss: 2^24 + 1
        sendBeat(32'h4B800000, 1'b0);
        sendBeat(32'h3F800000, 1'b1);
        checkResult("t7", 32'h4B800000, 3'd2, 3'b001);
        release_("t7");

        // Signalling NaN first beat is canonicalised; infinity is not a NaN
        sendBeat(32'h7F800001, 1'b1);
        checkResult("t8_snan", 32'h7FC00000, 3'd1, 3'b010);
        release_("t8");
        sendBeat(32'h7F800000, 1'b1);
        checkResult("t8_inf", 32'h7F800000, 3'd1, 3'b000);
        release_("t8b");

        // Reset mid-stream, then a fresh stream
        sendBeat(32'h40000000, 1'b0);
        sendBeat(32'h40000000, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkEq("t6_valid", outValid, 1'b0);
        checkEq("t6_ready", inReady, 1'b1);
        checkEq("t6_count", outCount, 3'd0);
        checkEq("t6_data", outData, 32'h0);
        sendBeat(32'h40000000, 1'b0);
        sendBeat(32'h40000000, 1'b1);
        checkResult("t6_new", 32'h40800000, 3'd2, 3'b000);
        release_("t6");

        // Count saturates at 2^CW-1 without raising any flag
        for (int i = 0; i < 9; i++) begin
            sendBeat(32'h00000000, i == 8);
        end
        checkResult("sat", 32'h00000000, 3'd7, 3'b000);
        release_("sat");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
